// File: rtl/atm_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_keypad_ctrl
// Purpose  : Keypad/card-reader front end for an ATM: PIN entry, menu,
//            amount entry and ATM handshake with a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module atm_keypad_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_detect,
   input  logic [7:0]  card_id,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        atm_success,
   input  logic [7:0]  atm_error,
   output logic        card_inserted,
   output logic [7:0]  card_number_input,
   output logic [15:0] pin_input,
   output logic        pin_valid,
   output logic        balance_req,
   output logic        withdrawal_req,
   output logic        deposit_req,
   output logic        transaction_done,
   output logic [15:0] amount,
   output logic [2:0]  ui_state,
   output logic        timeout_err
);

   localparam logic [3:0] KEY_ENTER    = 4'hA;
   localparam logic [3:0] KEY_CLEAR    = 4'hB;
   localparam logic [3:0] KEY_BALANCE  = 4'hC;
   localparam logic [3:0] KEY_WITHDRAW = 4'hD;
   localparam logic [3:0] KEY_DEPOSIT  = 4'hE;
   localparam logic [3:0] KEY_CANCEL   = 4'hF;
   localparam logic [7:0] WAIT_LIMIT   = 8'd254;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PIN    = 3'd1,
      ST_MENU   = 3'd2,
      ST_AMOUNT = 3'd3,
      ST_WAIT   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        card_det_q;
   logic [7:0]  card_num_q, card_num_d;
   logic [15:0] pin_q, pin_d;
   logic [2:0]  pin_cnt_q, pin_cnt_d;
   logic [15:0] amount_q, amount_d;
   logic        is_dep_q, is_dep_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic        ins_q, ins_d, pinv_q, pinv_d, bal_q, bal_d;
   logic        wd_q, wd_d, dep_q, dep_d, done_q, done_d;

   logic        is_digit;
   logic        key_cancel;
   logic [19:0] amount_calc;

   assign is_digit    = (key_code <= 4'd9);
   assign key_cancel  = key_valid && (key_code == KEY_CANCEL);
   // 20-bit headroom: 65535*10+9 still fits, so overflow is visible in [19:16]
   assign amount_calc = ({4'd0, amount_q} * 20'd10) + {16'd0, key_code};

   always_comb begin
      state_d    = state_q;
      card_num_d = card_num_q;
      pin_d      = pin_q;
      pin_cnt_d  = pin_cnt_q;
      amount_d   = amount_q;
      is_dep_d   = is_dep_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      ins_d      = 1'b0;
      pinv_d     = 1'b0;
      bal_d      = 1'b0;
      wd_d       = 1'b0;
      dep_d      = 1'b0;
      done_d     = 1'b0;

      // Card removal or CANCEL abandons the session ahead of any key or ATM reply
      if ((state_q != ST_IDLE) && (!card_detect || key_cancel)) begin
         state_d   = ST_IDLE;
         pin_d     = 16'd0;
         pin_cnt_d = 3'd0;
         amount_d  = 16'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (card_detect && !card_det_q) begin
                  card_num_d = card_id;
                  ins_d      = 1'b1;
                  timeout_d  = 1'b0;
                  pin_d      = 16'd0;
                  pin_cnt_d  = 3'd0;
                  state_d    = ST_PIN;
               end
            end
            ST_PIN: begin
               if (key_valid) begin
                  if (is_digit) begin
                     if (pin_cnt_q != 3'd4) begin
                        pin_d     = {pin_q[11:0], key_code};
                        pin_cnt_d = pin_cnt_q + 3'd1;
                     end
                  end else if (key_code == KEY_CLEAR) begin
                     pin_d     = 16'd0;
                     pin_cnt_d = 3'd0;
                  end else if ((key_code == KEY_ENTER) && (pin_cnt_q == 3'd4)) begin
                     pinv_d  = 1'b1;
                     state_d = ST_MENU;
                  end
               end
            end
            ST_MENU: begin
               if (key_valid) begin
                  if (key_code == KEY_BALANCE) begin
                     bal_d      = 1'b1;
                     wait_cnt_d = 8'd0;
                     state_d    = ST_WAIT;
                  end else if ((key_code == KEY_WITHDRAW) || (key_code == KEY_DEPOSIT)) begin
                     is_dep_d = (key_code == KEY_DEPOSIT);
                     amount_d = 16'd0;
                     state_d  = ST_AMOUNT;
                  end
               end
            end
            ST_AMOUNT: begin
               if (key_valid) begin
                  if (is_digit) begin
                     amount_d = (amount_calc[19:16] != 4'd0) ? 16'hFFFF : amount_calc[15:0];
                  end else if (key_code == KEY_CLEAR) begin
                     amount_d = 16'd0;
                  end else if ((key_code == KEY_ENTER) && (amount_q != 16'd0)) begin
                     dep_d      = is_dep_q;
                     wd_d       = !is_dep_q;
                     wait_cnt_d = 8'd0;
                     state_d    = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (atm_success) begin
                  done_d  = 1'b1;
                  state_d = ST_MENU;
               end else if (atm_error != 8'd0) begin
                  amount_d = 16'd0;
                  state_d  = ST_MENU;
               end else if (wait_cnt_q == WAIT_LIMIT) begin
                  timeout_d = 1'b1;
                  state_d   = ST_MENU;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // card_det_q resets high so a card already present at reset release is not an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         card_det_q <= 1'b1;
         card_num_q <= 8'd0;
         pin_q      <= 16'd0;
         pin_cnt_q  <= 3'd0;
         amount_q   <= 16'd0;
         is_dep_q   <= 1'b0;
         wait_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
         ins_q      <= 1'b0;
         pinv_q     <= 1'b0;
         bal_q      <= 1'b0;
         wd_q       <= 1'b0;
         dep_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         card_det_q <= card_detect;
         card_num_q <= card_num_d;
         pin_q      <= pin_d;
         pin_cnt_q  <= pin_cnt_d;
         amount_q   <= amount_d;
         is_dep_q   <= is_dep_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         ins_q      <= ins_d;
         pinv_q     <= pinv_d;
         bal_q      <= bal_d;
         wd_q       <= wd_d;
         dep_q      <= dep_d;
         done_q     <= done_d;
      end
   end

   assign card_inserted     = ins_q;
   assign card_number_input = card_num_q;
   assign pin_input         = pin_q;
   assign pin_valid         = pinv_q;
   assign balance_req       = bal_q;
   assign withdrawal_req    = wd_q;
   assign deposit_req       = dep_q;
   assign transaction_done  = done_q;
   assign amount            = amount_q;
   assign ui_state          = state_q;
   assign timeout_err       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_keypad_ctrl
// Purpose  : Directed scenarios plus random keypad/ATM traffic for
//            atm_keypad_ctrl, checked against a session-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_keypad_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        card_detect = 1'b0;
   logic [7:0]  card_id = 8'd0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        atm_success = 1'b0;
   logic [7:0]  atm_error = 8'd0;
   logic        card_inserted, pin_valid, balance_req, withdrawal_req;
   logic        deposit_req, transaction_done, timeout_err;
   logic [7:0]  card_number_input;
   logic [15:0] pin_input, amount;
   logic [2:0]  ui_state;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: session view (0 idle,1 pin,2 menu,3 amount,4 wait)
   int m_state, m_pin, m_digits, m_amt, m_dep, m_wait, m_to, m_card, m_prev;
   bit e_ins, e_pv, e_bal, e_wd, e_dep, e_done;

   atm_keypad_ctrl dut (
      .clk(clk), .rst_n(rst_n), .card_detect(card_detect), .card_id(card_id),
      .key_valid(key_valid), .key_code(key_code), .atm_success(atm_success),
      .atm_error(atm_error), .card_inserted(card_inserted),
      .card_number_input(card_number_input), .pin_input(pin_input),
      .pin_valid(pin_valid), .balance_req(balance_req),
      .withdrawal_req(withdrawal_req), .deposit_req(deposit_req),
      .transaction_done(transaction_done), .amount(amount),
      .ui_state(ui_state), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pin = 0; m_digits = 0; m_amt = 0; m_dep = 0;
      m_wait = 0; m_to = 0; m_card = 0; m_prev = 1;
      {e_ins, e_pv, e_bal, e_wd, e_dep, e_done} = '0;
   endtask

   task automatic end_session();
      m_state = 0; m_pin = 0; m_digits = 0; m_amt = 0;
   endtask

   task automatic model_step();
      int k;
      k = int'(key_code);
      {e_ins, e_pv, e_bal, e_wd, e_dep, e_done} = '0;
      if (m_state != 0 && (!card_detect || (key_valid && k == 15))) begin
         end_session();
      end else begin
         case (m_state)
            0: if (card_detect && m_prev == 0) begin
                  m_card = int'(card_id); e_ins = 1; m_to = 0;
                  m_pin = 0; m_digits = 0; m_state = 1;
               end
            1: if (key_valid) begin
                  if (k < 10) begin
                     if (m_digits < 4) begin
                        m_pin = (m_pin * 16 + k) % 65536;
                        m_digits++;
                     end
                  end else if (k == 11) begin
                     m_pin = 0; m_digits = 0;
                  end else if (k == 10 && m_digits == 4) begin
                     e_pv = 1; m_state = 2;
                  end
               end
            2: if (key_valid) begin
                  if (k == 12) begin
                     e_bal = 1; m_wait = 0; m_state = 4;
                  end else if (k == 13 || k == 14) begin
                     m_dep = (k == 14); m_amt = 0; m_state = 3;
                  end
               end
            3: if (key_valid) begin
                  if (k < 10) begin
                     m_amt = m_amt * 10 + k;
                     if (m_amt > 65535) m_amt = 65535;
                  end else if (k == 11) begin
                     m_amt = 0;
                  end else if (k == 10 && m_amt != 0) begin
                     if (m_dep != 0) e_dep = 1; else e_wd = 1;
                     m_wait = 0; m_state = 4;
                  end
               end
            4: if (atm_success) begin
                  e_done = 1; m_state = 2;
               end else if (atm_error != 0) begin
                  m_amt = 0; m_state = 2;
               end else begin
                  m_wait++;
                  if (m_wait == 255) begin
                     m_to = 1; m_state = 2;
                  end
               end
            default: m_state = 0;
         endcase
      end
      m_prev = card_detect;
   endtask

   task automatic check_all();
      chk("card_inserted",     20'(card_inserted),     20'(e_ins));
      chk("card_number_input", 20'(card_number_input), 20'(m_card));
      chk("pin_input",         20'(pin_input),         20'(m_pin));
      chk("pin_valid",         20'(pin_valid),         20'(e_pv));
      chk("balance_req",       20'(balance_req),       20'(e_bal));
      chk("withdrawal_req",    20'(withdrawal_req),    20'(e_wd));
      chk("deposit_req",       20'(deposit_req),       20'(e_dep));
      chk("transaction_done",  20'(transaction_done),  20'(e_done));
      chk("amount",            20'(amount),            20'(m_amt));
      chk("ui_state",          20'(ui_state),          20'(m_state));
      chk("timeout_err",       20'(timeout_err),       20'(m_to));
   endtask

   // One clock cycle: apply inputs at the falling edge, check just after the rising edge
   task automatic drive(input bit cd, input logic [7:0] cid, input bit kv,
                        input logic [3:0] kc, input bit s, input logic [7:0] e);
      @(negedge clk);
      rst_n = 1'b1;
      card_detect = cd; card_id = cid; key_valid = kv; key_code = kc;
      atm_success = s; atm_error = e;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic key(input logic [3:0] kc);
      drive(card_detect, card_id, 1'b1, kc, 1'b0, 8'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(card_detect, card_id, 1'b0, 4'd0, 1'b0, 8'd0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0; key_valid = 1'b0; atm_success = 1'b0; atm_error = 8'd0;
      #1;
      model_reset();
      check_all();
   endtask

   initial begin
      bit cd;
      model_reset();
      card_detect = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all();

      // Card already present at reset release: no session starts
      idle(3);
      chk("stay_idle_card_present", 20'(ui_state), 20'd0);

      // Insert card 0x00, PIN 1234
      drive(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'd0);
      drive(1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'd0);
      chk("insert_pulse", 20'(card_inserted), 20'd1);
      idle(1);
      chk("insert_pulse_end", 20'(card_inserted), 20'd0);
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
      key(4'hA);
      chk("pin_1234", 20'(pin_input), 20'h1234);
      chk("pin_valid_pulse", 20'(pin_valid), 20'd1);
      chk("menu_after_pin", 20'(ui_state), 20'd2);
      idle(1);
      chk("pin_valid_end", 20'(pin_valid), 20'd0);

      // Withdraw 80
      key(4'hD); key(4'd8); key(4'd0); key(4'hA);
      chk("amount_80", 20'(amount), 20'h0050);
      chk("withdraw_pulse", 20'(withdrawal_req), 20'd1);
      chk("wait_state", 20'(ui_state), 20'd4);
      idle(2);
      drive(1'b1, 8'h00, 1'b0, 4'd0, 1'b1, 8'd0);
      chk("done_pulse", 20'(transaction_done), 20'd1);
      chk("menu_after_done", 20'(ui_state), 20'd2);
      idle(1);

      // New card 0x5A; short PIN rejected, CLEAR then 5678(9 ignored)
      key(4'hF);
      drive(1'b0, 8'h5A, 1'b0, 4'd0, 1'b0, 8'd0);
      drive(1'b1, 8'h5A, 1'b0, 4'd0, 1'b0, 8'd0);
      chk("card_num_5a", 20'(card_number_input), 20'h5A);
      key(4'd1); key(4'd2); key(4'hA);
      chk("short_pin_no_valid", 20'(pin_valid), 20'd0);
      key(4'hB); key(4'd5); key(4'd6); key(4'd7); key(4'd8); key(4'd9); key(4'hA);
      chk("pin_5678", 20'(pin_input), 20'h5678);
      chk("pin_5678_valid", 20'(pin_valid), 20'd1);

      // Deposit with saturation, zero-amount ENTER ignored first
      key(4'hE); key(4'hA);
      chk("zero_enter_ignored", 20'(ui_state), 20'd3);
      for (int i = 0; i < 6; i++) key(4'd9);
      chk("amount_sat", 20'(amount), 20'hFFFF);
      key(4'hA);
      chk("deposit_pulse", 20'(deposit_req), 20'd1);

      // No ATM reply -> timeout, then balance answered with an error
      idle(254);
      chk("still_waiting", 20'(ui_state), 20'd4);
      idle(1);
      chk("timeout_menu", 20'(ui_state), 20'd2);
      chk("timeout_flag", 20'(timeout_err), 20'd1);
      key(4'hC);
      chk("balance_pulse", 20'(balance_req), 20'd1);
      drive(1'b1, 8'h5A, 1'b0, 4'd0, 1'b0, 8'h02);
      chk("err_amount_zero", 20'(amount), 20'd0);
      chk("err_no_done", 20'(transaction_done), 20'd0);
      chk("err_menu", 20'(ui_state), 20'd2);

      // Card pulled in the same cycle as ENTER in AMOUNT
      key(4'hD); key(4'd5);
      drive(1'b0, 8'h5A, 1'b1, 4'hA, 1'b0, 8'd0);
      chk("pull_idle", 20'(ui_state), 20'd0);
      chk("pull_no_req", 20'(withdrawal_req), 20'd0);
      chk("pull_amount_zero", 20'(amount), 20'd0);

      // New card clears timeout; reset mid-WAIT
      drive(1'b1, 8'hC3, 1'b0, 4'd0, 1'b0, 8'd0);
      chk("timeout_cleared", 20'(timeout_err), 20'd0);
      key(4'd4); key(4'd3); key(4'd2); key(4'd1); key(4'hA); key(4'hC);
      async_reset();
      chk("reset_idle", 20'(ui_state), 20'd0);
      chk("reset_card_num", 20'(card_number_input), 20'd0);
      idle(2);

      // Random traffic
      cd = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] kc;
         logic [7:0] err;
         if (cd) cd = ($urandom_range(0, 59) != 0);
         else    cd = ($urandom_range(0, 2) == 0);
         kc = ($urandom_range(0, 4) == 0) ? 4'hA : 4'($urandom_range(0, 15));
         if (kc == 4'hF && $urandom_range(0, 3) != 0) kc = 4'd7;
         err = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         drive(cd, 8'($urandom), 1'($urandom_range(0, 1)), kc,
               ($urandom_range(0, 15) == 0), err);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/atm_keypad_ctrl.md
ATM_KEYPAD_CTRL -- requirements
Module: atm_keypad_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port card_detect  input  1  card reader level; 1 = card present.
REQ-004 SHALL have port card_id  input  8  card number from reader, valid while card_detect=1.
REQ-005 SHALL have port key_valid  input  1  one-cycle keypad strobe.
REQ-006 SHALL have port key_code  input  4  0-9 digit, A ENTER, B CLEAR, C BALANCE, D WITHDRAW, E DEPOSIT, F CANCEL.
REQ-007 SHALL have port atm_success  input  1  ATM transaction_success.
REQ-008 SHALL have port atm_error  input  8  ATM error_code; nonzero = failure.
REQ-009 SHALL have port card_inserted  output  1  one-cycle pulse to ATM.
REQ-010 SHALL have port card_number_input  output  8  latched card_id.
REQ-011 SHALL have port pin_input  output  16  4-digit BCD PIN, first digit in [15:12].
REQ-012 SHALL have port pin_valid  output  1  one-cycle pulse, PIN complete.
REQ-013 SHALL have ports balance_req, withdrawal_req, deposit_req, transaction_done  output  1 each  one-cycle pulses.
REQ-014 SHALL have port amount  output  16  binary amount; stable from request pulse until leaving WAIT.
REQ-015 SHALL have ports ui_state  output  3 (encoding per REQ-020) and timeout_err  output  1  sticky, cleared on next card_inserted.

Function
REQ-016 All outputs SHALL be registered; every pulse output SHALL be high exactly one cycle.
REQ-017 card_detect SHALL be registered once; card rising edge = registered 0 -> current 1.
REQ-018 Key events SHALL be acted on only in the cycle key_valid=1; key_valid in IDLE ignored.
REQ-019 Undefined-for-state keys SHALL be ignored with no output change.
REQ-020 FSM states: IDLE=0, PIN=1, MENU=2, AMOUNT=3, WAIT=4.
REQ-021 IDLE: on card rising edge, latch card_number_input=card_id, pulse card_inserted the next cycle, clear pin/count, enter PIN.
REQ-022 PIN: digit 0-9 -> pin_input={pin_input[11:0],digit}, count+1; digits when count=4 ignored; CLEAR -> pin_input=0, count=0; ENTER with count=4 -> pin_valid pulse next cycle, enter MENU; ENTER with count<4 ignored.
REQ-023 MENU: BALANCE -> balance_req pulse, enter WAIT; WITHDRAW/DEPOSIT -> latch type, amount=0, enter AMOUNT.
REQ-024 AMOUNT: digit -> amount=amount*10+digit computed 20-bit, saturating to 16'hFFFF; CLEAR -> 0; ENTER with amount!=0 -> withdrawal_req or deposit_req per latched type, enter WAIT; ENTER with amount=0 ignored.
REQ-025 WAIT: atm_success=1 -> transaction_done pulse, enter MENU; else atm_error!=0 -> amount=0, enter MENU, no transaction_done; success wins if both.
REQ-026 WAIT: 8-bit counter cleared on entry; 255 cycles without response -> timeout_err=1, enter MENU.
REQ-027 CANCEL in any non-IDLE state -> IDLE, pin_input=0, amount=0, no pulses.
REQ-028 card_detect=0 in any non-IDLE state -> same as CANCEL; highest priority, overriding a same-cycle key or ATM response.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and all outputs to 0 (pin_input, amount, card_number_input 0; pulses and timeout_err 0), including mid-transaction.
REQ-030 After rst_n release with card_detect already 1, SHALL stay IDLE until card_detect falls and rises again (registered card_detect resets to 1-safe: treated as present, no edge).

Verification
REQ-031 card_detect 0->1, card_id=0x00, keys 1,2,3,4,ENTER -> card_inserted one pulse, card_number_input=0x00, pin_input=0x1234, pin_valid one pulse, ui_state=2.
REQ-032 From MENU: WITHDRAW,8,0,ENTER -> amount=0x0050, withdrawal_req one pulse, ui_state=4; atm_success pulse -> transaction_done one pulse, ui_state=2.
REQ-033 PIN keys 1,2,ENTER -> no pin_valid; CLEAR,5,6,7,8,9,ENTER -> pin_input=0x5678, pin_valid pulse.
REQ-034 AMOUNT keys 9,9,9,9,9,9 -> amount=0xFFFF saturated; DEPOSIT path ENTER -> deposit_req pulse.
REQ-035 WAIT with no ATM response 255 cycles -> timeout_err=1, ui_state=2; atm_error=0x02 in WAIT -> MENU, amount=0, no transaction_done.
REQ-036 card_detect 1->0 coincident with ENTER in AMOUNT, and rst_n=0 mid-WAIT -> ui_state=0, no request pulse, all outputs 0 (reset case).
